// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter for the CPU data bus with a bounded hold count.
// Read data is returned to the master that issued the read one cycle earlier.
module dbus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int HOLD_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_waddr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  input  logic                  m0_rd,
  input  logic [ADDR_WIDTH-1:0] m0_raddr,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_waddr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  input  logic                  m1_rd,
  input  logic [ADDR_WIDTH-1:0] m1_raddr,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,
  output logic                  dmem_wr,
  output logic [ADDR_WIDTH-1:0] dmem_waddr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  output logic                  dmem_rd,
  output logic [ADDR_WIDTH-1:0] dmem_raddr,
  input  logic [31:0]           dmem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       last_ptr_q, last_ptr_d;
  logic       rd_pend_q, rd_owner_q;

  logic req0, req1, own_req, oth_req;

  assign req0 = m0_wr | m0_rd;
  assign req1 = m1_wr | m1_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= 8'd0;
      last_ptr_q <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_ptr_q <= last_ptr_d;
      rd_pend_q  <= dmem_rd;
      rd_owner_q <= m1_gnt;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_ptr_d = last_ptr_q;
    own_req    = 1'b0;
    oth_req    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = last_ptr_q ? OWN0 : OWN1;
        else if (req0)    state_d = OWN0;
        else if (req1)    state_d = OWN1;
      end
      OWN0: begin
        own_req = req0;
        oth_req = req1;
        if (!req0)                                state_d = req1 ? OWN1 : IDLE;
        else if (req1 && hold_cnt_q == HOLD_LAST) state_d = OWN1;
      end
      OWN1: begin
        own_req = req1;
        oth_req = req0;
        if (!req1)                                state_d = req0 ? OWN0 : IDLE;
        else if (req0 && hold_cnt_q == HOLD_LAST) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase

    // Only transfers made while the other master waits count toward the hold limit.
    if (state_d != state_q)
      hold_cnt_d = 8'd0;
    else if (own_req && oth_req && hold_cnt_q != HOLD_LAST)
      hold_cnt_d = hold_cnt_q + 8'd1;

    if (state_d == OWN0 && state_q != OWN0) last_ptr_d = 1'b0;
    if (state_d == OWN1 && state_q != OWN1) last_ptr_d = 1'b1;
  end

  assign m0_gnt = (state_q == OWN0);
  assign m1_gnt = (state_q == OWN1);

  always_comb begin
    dmem_wr    = 1'b0;
    dmem_waddr = '0;
    dmem_wdata = 32'h0;
    dmem_wstrb = 4'h0;
    dmem_rd    = 1'b0;
    dmem_raddr = '0;
    if (m0_gnt && m0_wr) begin
      dmem_wr    = 1'b1;
      dmem_waddr = m0_waddr;
      dmem_wdata = m0_wdata;
      dmem_wstrb = m0_wstrb;
    end else if (m1_gnt && m1_wr) begin
      dmem_wr    = 1'b1;
      dmem_waddr = m1_waddr;
      dmem_wdata = m1_wdata;
      dmem_wstrb = m1_wstrb;
    end
    if (m0_gnt && m0_rd) begin
      dmem_rd    = 1'b1;
      dmem_raddr = m0_raddr;
    end else if (m1_gnt && m1_rd) begin
      dmem_rd    = 1'b1;
      dmem_raddr = m1_raddr;
    end
  end

  // A reset arriving while a read is in flight drops the return immediately.
  assign m0_rvalid = rd_pend_q & ~rd_owner_q & ~rst;
  assign m1_rvalid = rd_pend_q &  rd_owner_q & ~rst;
  assign m0_rdata  = m0_rvalid ? dmem_rdata : 32'h0;
  assign m1_rdata  = m1_rvalid ? dmem_rdata : 32'h0;

endmodule
